// File: rtl/lap_time_counter.sv
// Lap timer: live MM:SS:CC as BCD and ASCII, plus the last completed lap.
// Optional BEST_LAP_EN adds best_ascii/new_best.
//
// Ports:
//   pclk, rst_n              clock, async active-low reset
//   start, stop, lap, clear  one-cycle control pulses
//   running                  high while counting
//   cur_ascii, cur_bcd       current time {M1,M0,S1,S0,C1,C0}
//   last_ascii               last completed lap
//   lap_done                 pulse one cycle after an accepted lap
//   overflow                 sticky, set at 59:59:99
//   best_ascii, new_best     best lap so far (BEST_LAP_EN only)
module lap_time_counter #(
   parameter int CLK_FREQ_HZ = 65000000,
   parameter int TICK_HZ     = 100
) (
   input  logic        pclk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        stop,
   input  logic        lap,
   input  logic        clear,
   output logic        running,
   output logic [41:0] cur_ascii,
   output logic [23:0] cur_bcd,
   output logic [41:0] last_ascii,
   output logic        lap_done,
   output logic        overflow
`ifdef BEST_LAP_EN
   ,
   output logic [41:0] best_ascii,
   output logic        new_best
`endif
);

   localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
   localparam int PW  = $clog2(DIV);
   localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
   localparam logic [23:0] SAT_T = 24'h595999;
   localparam logic [41:0] ZERO_A = {6{7'h30}};

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PAUSE,
      SAT
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [23:0]   cur_q, cur_d;
   logic [23:0]   inc;
   logic          ovf_d;
   logic          lap_take;
   logic          cnt_en;

   // Digit order C0,C1,S0,S1,M0,M1 from bit 0 upward; tens of
   // seconds and tens of minutes roll over at 5.
   function automatic logic [23:0] bcd_inc(input logic [23:0] t);
      logic [23:0] r;
      logic        c;
      logic [3:0]  lim;
      r = t;
      c = 1'b1;
      for (int i = 0; i < 6; i++) begin
         lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
         if (c) begin
            if (r[i*4 +: 4] == lim) begin
               r[i*4 +: 4] = 4'd0;
            end else begin
               r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [41:0] to_ascii(input logic [23:0] t);
      logic [41:0] a;
      for (int i = 0; i < 6; i++)
         a[i*7 +: 7] = 7'h30 + {3'b000, t[i*4 +: 4]};
      return a;
   endfunction

   assign lap_take = lap && !clear && (state_q != IDLE);
   // stop wins over the prescaler so a pause holds its exact phase
   assign cnt_en = (state_q == RUN) && !clear && !lap_take && !stop;
   assign inc = bcd_inc(cur_q);
   assign cur_bcd = cur_q;

   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      cur_d   = cur_q;
      ovf_d   = overflow;
      if (clear) begin
         state_d = IDLE;
         pre_d   = '0;
         cur_d   = '0;
         ovf_d   = 1'b0;
      end else if (lap_take) begin
         pre_d = '0;
         cur_d = '0;
         ovf_d = 1'b0;
         if (state_q == SAT)
            state_d = RUN;
      end else if (stop) begin
         if (state_q == RUN)
            state_d = PAUSE;
      end else if (start) begin
         if (state_q == IDLE || state_q == PAUSE)
            state_d = RUN;
      end
      if (cnt_en) begin
         if (pre_q == PMAX) begin
            pre_d = '0;
            cur_d = inc;
            if (inc == SAT_T) begin
               state_d = SAT;
               ovf_d   = 1'b1;
            end
         end else begin
            pre_d = pre_q + 1'b1;
         end
      end
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pre_q      <= '0;
         cur_q      <= '0;
         cur_ascii  <= ZERO_A;
         last_ascii <= ZERO_A;
         lap_done   <= 1'b0;
         overflow   <= 1'b0;
         running    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pre_q     <= pre_d;
         cur_q     <= cur_d;
         cur_ascii <= to_ascii(cur_d);
         overflow  <= ovf_d;
         running   <= (state_d == RUN);
         lap_done  <= lap_take;
         if (clear)
            last_ascii <= ZERO_A;
         else if (lap_take)
            last_ascii <= to_ascii(cur_q);
      end
   end

`ifdef BEST_LAP_EN
   logic [23:0] best_q;

   // BCD digits compare correctly as a plain binary number
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         best_q     <= SAT_T;
         best_ascii <= to_ascii(SAT_T);
         new_best   <= 1'b0;
      end else if (clear) begin
         best_q     <= SAT_T;
         best_ascii <= to_ascii(SAT_T);
         new_best   <= 1'b0;
      end else if (lap_take && (cur_q < best_q)) begin
         best_q     <= cur_q;
         best_ascii <= to_ascii(cur_q);
         new_best   <= 1'b1;
      end else begin
         new_best <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_lap_time_counter.sv
// Self-checking bench for lap_time_counter.
// Directed table plus hand sequences for carries, saturation, reset.
module tb_lap_time_counter;

   logic        pclk;
   logic        rst_n;
   logic        start, stop, lap, clear;
   logic        running;
   logic [41:0] cur_ascii;
   logic [23:0] cur_bcd;
   logic [41:0] last_ascii;
   logic        lap_done;
   logic        overflow;
`ifdef BEST_LAP_EN
   logic [41:0] best_ascii;
   logic        new_best;
`endif

   int pass_cnt = 0;
   int total    = 0;
   logic [23:0] fv;

   lap_time_counter #(
      .CLK_FREQ_HZ(1000),
      .TICK_HZ    (100)
   ) dut (
      .pclk      (pclk),
      .rst_n     (rst_n),
      .start     (start),
      .stop      (stop),
      .lap       (lap),
      .clear     (clear),
      .running   (running),
      .cur_ascii (cur_ascii),
      .cur_bcd   (cur_bcd),
      .last_ascii(last_ascii),
      .lap_done  (lap_done),
      .overflow  (overflow)
`ifdef BEST_LAP_EN
      ,
      .best_ascii(best_ascii),
      .new_best  (new_best)
`endif
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   typedef struct {
      logic [3:0]  ev;
      int          n;
      logic [23:0] cur;
      logic        run;
      logic        ld;
      logic        ov;
      logic [23:0] last;
   } vec_t;

   vec_t tbl[14];

   function automatic logic [41:0] asc(input logic [23:0] t);
      logic [41:0] a;
      for (int i = 0; i < 6; i++)
         a[i*7 +: 7] = 7'h30 + {3'b000, t[i*4 +: 4]};
      return a;
   endfunction

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else
         pass_cnt++;
   endtask

   // ev = {start, stop, lap, clear}; called and returns at a negedge
   task automatic pulse(input logic [3:0] ev);
      {start, stop, lap, clear} = ev;
      @(negedge pclk);
      {start, stop, lap, clear} = 4'b0000;
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge pclk);
   endtask

   // Preload a time while IDLE, start, and watch the very next tick.
   task automatic run_from(input logic [23:0] v, input logic [23:0] nxt,
                           input string nm);
      pulse(4'b0001);
      fv = v;
      force dut.cur_q = fv;
      step(2);
      release dut.cur_q;
      pulse(4'b1000);
      step(9);
      check({nm, " hold"}, 64'(cur_bcd), 64'(v));
      step(1);
      check({nm, " bcd"}, 64'(cur_bcd), 64'(nxt));
      check({nm, " ascii"}, 64'(cur_ascii), 64'(asc(nxt)));
   endtask

   initial begin
      rst_n = 1'b0;
      {start, stop, lap, clear} = 4'b0000;

      tbl[0]  = '{4'b0000, 0,     24'h000000, 0, 0, 0, 24'h0};
      tbl[1]  = '{4'b1000, 9,     24'h000000, 1, 0, 0, 24'h0};
      tbl[2]  = '{4'b0000, 1,     24'h000001, 1, 0, 0, 24'h0};
      tbl[3]  = '{4'b0000, 980,   24'h000099, 1, 0, 0, 24'h0};
      tbl[4]  = '{4'b0000, 10,    24'h000100, 1, 0, 0, 24'h0};
      tbl[5]  = '{4'b0000, 5,     24'h000100, 1, 0, 0, 24'h0};
      tbl[6]  = '{4'b0100, 0,     24'h000100, 0, 0, 0, 24'h0};
      tbl[7]  = '{4'b0000, 100,   24'h000100, 0, 0, 0, 24'h0};
      tbl[8]  = '{4'b1000, 4,     24'h000100, 1, 0, 0, 24'h0};
      tbl[9]  = '{4'b0000, 1,     24'h000101, 1, 0, 0, 24'h0};
      tbl[10] = '{4'b0000, 11330, 24'h001234, 1, 0, 0, 24'h0};
      tbl[11] = '{4'b0010, 0,     24'h000000, 1, 1, 0, 24'h001234};
      tbl[12] = '{4'b0000, 1,     24'h000000, 1, 0, 0, 24'h001234};
      tbl[13] = '{4'b0000, 9,     24'h000001, 1, 0, 0, 24'h001234};

      step(3);
      rst_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         if (tbl[i].ev != 4'b0000)
            pulse(tbl[i].ev);
         step(tbl[i].n);
         check($sformatf("row%0d cur_bcd", i),
               64'(cur_bcd), 64'(tbl[i].cur));
         check($sformatf("row%0d cur_ascii", i),
               64'(cur_ascii), 64'(asc(tbl[i].cur)));
         check($sformatf("row%0d running", i),
               64'(running), 64'(tbl[i].run));
         check($sformatf("row%0d lap_done", i),
               64'(lap_done), 64'(tbl[i].ld));
         check($sformatf("row%0d overflow", i),
               64'(overflow), 64'(tbl[i].ov));
         check($sformatf("row%0d last_ascii", i),
               64'(last_ascii), 64'(asc(tbl[i].last)));
      end

      run_from(24'h000999, 24'h001000, "s0 carry");
      run_from(24'h005999, 24'h010000, "s1 carry");
      run_from(24'h095999, 24'h100000, "m0 carry");

      run_from(24'h595998, 24'h595999, "sat tick");
      check("sat ovf", 64'(overflow), 64'd1);
      check("sat run", 64'(running), 64'd0);
      step(200);
      check("sat frozen", 64'(cur_bcd), 64'h595999);
      check("sat ovf held", 64'(overflow), 64'd1);
      pulse(4'b0010);
      check("sat lap last", 64'(last_ascii), 64'(asc(24'h595999)));
      check("sat lap ovf", 64'(overflow), 64'd0);
      check("sat lap run", 64'(running), 64'd1);
      check("sat lap done", 64'(lap_done), 64'd1);
      check("sat lap cur", 64'(cur_bcd), 64'd0);
      step(1);
      check("sat lap done off", 64'(lap_done), 64'd0);

      step(19);
      check("pre clr cur", 64'(cur_bcd), 64'h000002);
      pulse(4'b1011);
      check("clr run", 64'(running), 64'd0);
      check("clr cur", 64'(cur_ascii), 64'(asc(24'h0)));
      check("clr last", 64'(last_ascii), 64'(asc(24'h0)));
      check("clr done", 64'(lap_done), 64'd0);
      step(20);
      check("clr idle cur", 64'(cur_bcd), 64'd0);
      pulse(4'b0010);
      check("idle lap done", 64'(lap_done), 64'd0);
      check("idle lap last", 64'(last_ascii), 64'(asc(24'h0)));

      pulse(4'b1000);
      step(35);
      check("pre rst cur", 64'(cur_bcd), 64'h000003);
      @(posedge pclk);
      #2 rst_n = 1'b0;
      #1;
      check("arst cur", 64'(cur_bcd), 64'd0);
      check("arst ascii", 64'(cur_ascii), 64'(asc(24'h0)));
      check("arst run", 64'(running), 64'd0);
      @(negedge pclk);
      rst_n = 1'b1;
      step(20);
      check("arst idle", 64'(cur_bcd), 64'd0);

`ifdef BEST_LAP_EN
      check("best init", 64'(best_ascii), 64'(asc(24'h595999)));
      pulse(4'b1000);
      step(5000);
      check("best l1 cur", 64'(cur_bcd), 64'h000500);
      pulse(4'b0010);
      check("best l1 nb", 64'(new_best), 64'd1);
      check("best l1 val", 64'(best_ascii), 64'(asc(24'h000500)));
      step(3000);
      pulse(4'b0010);
      check("best l2 nb", 64'(new_best), 64'd1);
      check("best l2 val", 64'(best_ascii), 64'(asc(24'h000300)));
      step(4000);
      pulse(4'b0010);
      check("best l3 nb", 64'(new_best), 64'd0);
      check("best l3 done", 64'(lap_done), 64'd1);
      check("best l3 val", 64'(best_ascii), 64'(asc(24'h000300)));
`endif

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
